// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: bus widths, load size codes, FSM states.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_W = 75;
    localparam int MS_TO_WS_BUS_W = 70;
    localparam int MS_FWD_BUS_W   = 39;

    localparam logic [2:0] MT_W  = 3'd0;
    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_BU = 3'd3;
    localparam logic [2:0] MT_HU = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } ms_state_e;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load alignment: picks the addressed byte/half of a word and extends it.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  addr,
    input  logic [2:0]  mem_type,
    output logic [31:0] result
);

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
        logic signed [7:0]  s;
        logic signed [31:0] w;
        s = b;
        w = s;
        return sgn ? w : {24'd0, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
        logic signed [15:0] s;
        logic signed [31:0] w;
        s = h;
        w = s;
        return sgn ? w : {16'd0, h};
    endfunction

    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    // addr[0] is ignored for halfwords; misaligned accesses never reach this stage
    assign byte_sh = raw >> {addr, 3'b000};
    assign half_sh = raw >> {addr[1], 4'b0000};

    always_comb begin
        result = raw;
        case (mem_type)
            MT_B:    result = ext8(byte_sh[7:0], 1'b1);
            MT_BU:   result = ext8(byte_sh[7:0], 1'b0);
            MT_H:    result = ext16(half_sh[15:0], 1'b1);
            MT_HU:   result = ext16(half_sh[15:0], 1'b0);
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: waits for the data-SRAM response, aligns load data,
// buffers the response while write-back stalls, and feeds bypass info to decode.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ES_TO_MS_BUS_WD = ES_TO_MS_BUS_W,
    parameter int MS_TO_WS_BUS_WD = MS_TO_WS_BUS_W,
    parameter int MS_FWD_BUS_WD   = MS_FWD_BUS_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic [MS_FWD_BUS_WD-1:0]   ms_to_ds_fwd_bus
);

    logic                       ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] ms_bus_p0;
    ms_state_e                  state;
    logic                       buf_valid;
    logic [31:0]                buf_rdata;

    logic [2:0]  ms_mem_type;
    logic        ms_store_op;
    logic        ms_load_op;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_exe_result;
    logic [31:0] ms_pc;

    assign {ms_mem_type, ms_store_op, ms_load_op, ms_gr_we,
            ms_dest, ms_exe_result, ms_pc} = ms_bus_p0;

    logic        ms_mem_op;
    logic        es_mem_op;
    logic        resp_ok;
    logic        ms_ready_go;
    logic        es_accept;
    logic [31:0] raw;
    logic [31:0] load_result;
    logic [31:0] ms_final_result;
    logic        fwd_valid;
    logic        fwd_blocked;

    assign ms_mem_op = ms_load_op | ms_store_op;
    assign es_mem_op = es_to_ms_bus[71] | es_to_ms_bus[70];

    // a response only counts while the resident op is waiting for one
    assign resp_ok     = data_sram_data_ok & (state == ST_WAIT);
    assign ms_ready_go = ~ms_mem_op | resp_ok | buf_valid;
    assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
    assign es_accept   = es_to_ms_valid & ms_allowin;

    assign ms_to_ws_valid = ms_valid & ms_ready_go;

    assign raw = buf_valid ? buf_rdata : data_sram_rdata;

    load_align u_load_align (
        .raw      (raw),
        .addr     (ms_exe_result[1:0]),
        .mem_type (ms_mem_type),
        .result   (load_result)
    );

    assign ms_final_result = ms_load_op ? load_result : ms_exe_result;

    assign ms_to_ws_bus = {ms_gr_we, ms_dest, ms_final_result, ms_pc};

    assign fwd_valid   = ms_valid & ms_gr_we & (ms_dest != 5'd0);
    assign fwd_blocked = ms_load_op & ~ms_ready_go;

    assign ms_to_ds_fwd_bus = {fwd_valid, fwd_blocked, ms_dest, ms_final_result};

    // stage register boundary: exe -> mem
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ms_valid  <= 1'b0;
            ms_bus_p0 <= '0;
            state     <= ST_IDLE;
            buf_valid <= 1'b0;
            buf_rdata <= 32'd0;
        end else begin
            if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end
            if (es_accept) begin
                ms_bus_p0 <= es_to_ms_bus;
            end

            // allowin means the resident op (if any) leaves this edge
            if (ms_allowin) begin
                state     <= (es_to_ms_valid && es_mem_op) ? ST_WAIT : ST_IDLE;
                buf_valid <= 1'b0;
            end else if (resp_ok) begin
                state     <= ST_HOLD;
                buf_valid <= 1'b1;
                buf_rdata <= data_sram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of mem_stage against a transaction-level model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [74:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [38:0] ms_to_ds_fwd_bus;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ms_to_ds_fwd_bus  (ms_to_ds_fwd_bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [74:0] mk(input logic [2:0] mt, input logic st, input logic ld,
                                       input logic we, input logic [4:0] dest,
                                       input logic [31:0] res, input logic [31:0] pc);
        return {mt, st, ld, we, dest, res, pc};
    endfunction

    // Load-extension rules written as plain shift/mask arithmetic.
    function automatic logic [31:0] align_ref(input logic [31:0] raw, input logic [1:0] a,
                                              input logic [2:0] mt);
        logic [31:0] v;
        v = raw;
        if (mt == 3'd1 || mt == 3'd3) begin
            v = (raw >> (8 * a)) & 32'hFF;
            if (mt == 3'd1 && v >= 32'd128) v = v - 32'd256;
        end else if (mt == 3'd2 || mt == 3'd4) begin
            v = (raw >> (16 * a[1])) & 32'hFFFF;
            if (mt == 3'd2 && v >= 32'd32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_allowin"}, ms_allowin, 1'b1);
        chk({tag, "_valid"}, ms_to_ws_valid, 1'b0);
        chk({tag, "_wsbus"}, ms_to_ws_bus, 70'd0);
        chk({tag, "_fwd"}, ms_to_ds_fwd_bus, 39'd0);
    endtask

    task automatic run_load(input string tag, input logic [2:0] mt, input logic [31:0] addr,
                            input logic [31:0] rd, input logic [31:0] exp);
        tick();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(mt, 1'b0, 1'b1, 1'b1, 5'd7, addr, 32'h0000_2000);
        ws_allowin     = 1'b1;
        data_sram_data_ok = 1'b0;
        settle();
        chk({tag, "_accept"}, ms_allowin, 1'b1);
        tick();
        es_to_ms_valid = 1'b0;
        settle();
        chk({tag, "_wait_allowin"}, ms_allowin, 1'b0);
        chk({tag, "_wait_blocked"}, ms_to_ds_fwd_bus[37], 1'b1);
        chk({tag, "_wait_valid"}, ms_to_ws_valid, 1'b0);
        tick();
        settle();
        chk({tag, "_wait2_valid"}, ms_to_ws_valid, 1'b0);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        settle();
        chk({tag, "_ok_valid"}, ms_to_ws_valid, 1'b1);
        chk({tag, "_result"}, ms_to_ws_bus[63:32], exp);
        chk({tag, "_fwd_data"}, ms_to_ds_fwd_bus[31:0], exp);
        chk({tag, "_ok_blocked"}, ms_to_ds_fwd_bus[37], 1'b0);
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        chk({tag, "_gone"}, ms_to_ws_valid, 1'b0);
    endtask

    // random-phase model state
    logic        off_v;
    logic [74:0] off_bus;
    logic        res;
    logic [74:0] rbus;
    logic        got;
    logic [31:0] rdat;
    logic [31:0] cur_rd;
    int          dly;
    logic        dok;
    logic        ready;
    logic        exp_allow;
    logic [31:0] exp_res;
    logic        r_mem;
    int          kind;

    initial begin
        reset             = 1'b0;
        ws_allowin        = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'd0;
        #2;
        chk_reset_outputs("rst");
        tick();
        reset = 1'b1;

        // ALU op passes through in one cycle
        tick();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(3'd0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234_5678, 32'h0000_1000);
        settle();
        chk("alu_allowin", ms_allowin, 1'b1);
        tick();
        es_to_ms_valid = 1'b0;
        settle();
        chk("alu_valid", ms_to_ws_valid, 1'b1);
        chk("alu_result", ms_to_ws_bus[63:32], 32'h1234_5678);
        chk("alu_fwd_valid", ms_to_ds_fwd_bus[38], 1'b1);
        chk("alu_fwd_blocked", ms_to_ds_fwd_bus[37], 1'b0);
        chk("alu_fwd_dest", ms_to_ds_fwd_bus[36:32], 5'd5);
        tick();
        settle();
        chk("alu_gone", ms_to_ws_valid, 1'b0);

        run_load("lb",  3'd1, 32'h0000_1003, 32'h80FF_0102, 32'hFFFF_FF80);
        run_load("lbu", 3'd3, 32'h0000_1003, 32'h80FF_0102, 32'h0000_0080);
        run_load("lh",  3'd2, 32'h0000_1002, 32'h8001_7FFF, 32'hFFFF_8001);
        run_load("lhu", 3'd4, 32'h0000_1002, 32'h8001_7FFF, 32'h0000_8001);

        // LW response buffered while write-back stalls
        tick();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(3'd0, 1'b0, 1'b1, 1'b1, 5'd9, 32'h0000_3000, 32'h0000_3004);
        tick();
        es_to_ms_valid    = 1'b0;
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        settle();
        chk("lw_ok_valid", ms_to_ws_valid, 1'b1);
        chk("lw_ok_allowin", ms_allowin, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = 'x;
            settle();
            chk("lw_hold_valid", ms_to_ws_valid, 1'b1);
            chk("lw_hold_result", ms_to_ws_bus[63:32], 32'hDEAD_BEEF);
            chk("lw_hold_allowin", ms_allowin, 1'b0);
        end
        tick();
        ws_allowin = 1'b1;
        settle();
        chk("lw_release_result", ms_to_ws_bus[63:32], 32'hDEAD_BEEF);
        chk("lw_release_allowin", ms_allowin, 1'b1);
        tick();
        settle();
        chk("lw_buf_cleared", dut.buf_valid, 1'b0);
        chk("lw_gone", ms_to_ws_valid, 1'b0);
        data_sram_rdata = 32'd0;

        // store stalls, ALU op follows back-to-back
        tick();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(3'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_4000, 32'h0000_4000);
        tick();
        es_to_ms_bus   = mk(3'd0, 1'b0, 1'b0, 1'b1, 5'd11, 32'hCAFE_0011, 32'h0000_4004);
        settle();
        chk("st_wait_allowin", ms_allowin, 1'b0);
        chk("st_wait_valid", ms_to_ws_valid, 1'b0);
        tick();
        data_sram_data_ok = 1'b1;
        settle();
        chk("st_ok_valid", ms_to_ws_valid, 1'b1);
        chk("st_ok_allowin", ms_allowin, 1'b1);
        chk("st_ok_pc", ms_to_ws_bus[31:0], 32'h0000_4000);
        tick();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b0;
        settle();
        chk("st_alu_valid", ms_to_ws_valid, 1'b1);
        chk("st_alu_result", ms_to_ws_bus[63:32], 32'hCAFE_0011);
        tick();
        settle();
        chk("st_alu_gone", ms_to_ws_valid, 1'b0);

        // asynchronous reset during WAIT, then a stray response
        tick();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(3'd0, 1'b0, 1'b1, 1'b1, 5'd3, 32'h0000_5000, 32'h0000_5000);
        tick();
        es_to_ms_valid = 1'b0;
        settle();
        chk("rw_wait_allowin", ms_allowin, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        chk_reset_outputs("rw");
        tick();
        reset = 1'b1;
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h5555_AAAA;
        settle();
        chk("rw_stray_valid", ms_to_ws_valid, 1'b0);
        chk("rw_stray_allowin", ms_allowin, 1'b1);
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        chk("rw_after_valid", ms_to_ws_valid, 1'b0);

        // asynchronous reset during HOLD
        tick();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = mk(3'd0, 1'b0, 1'b1, 1'b1, 5'd4, 32'h0000_6000, 32'h0000_6000);
        tick();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_0012;
        ws_allowin        = 1'b0;
        tick();
        data_sram_data_ok = 1'b0;
        settle();
        chk("rh_hold_valid", ms_to_ws_valid, 1'b1);
        reset = 1'b0;
        #1;
        chk_reset_outputs("rh");
        chk("rh_buf", dut.buf_valid, 1'b0);
        tick();
        reset      = 1'b1;
        ws_allowin = 1'b1;
        settle();
        chk("rh_after_valid", ms_to_ws_valid, 1'b0);

        // randomized traffic against the transaction model
        off_v = 1'b0;
        res   = 1'b0;
        got   = 1'b0;
        dly   = 0;
        rbus  = '0;
        rdat  = 32'd0;
        off_bus = '0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (!off_v) begin
                off_v = ($urandom % 4) != 0;
                kind  = int'($urandom % 3);
                off_bus = mk(3'($urandom % 8), kind == 2, kind == 1, kind != 2,
                             5'($urandom % 32), $urandom, $urandom);
            end
            ws_allowin = ($urandom % 10) < 7;
            r_mem  = rbus[71] | rbus[70];
            dok    = 1'b0;
            cur_rd = $urandom;
            if (res && r_mem && !got) begin
                if (dly == 0) dok = 1'b1;
                else dly--;
            end
            es_to_ms_valid    = off_v;
            es_to_ms_bus      = off_bus;
            data_sram_data_ok = dok;
            data_sram_rdata   = cur_rd;
            settle();

            ready     = res && (!r_mem || got || dok);
            exp_allow = !res || (ready && ws_allowin);
            exp_res   = rbus[70] ? align_ref(got ? rdat : cur_rd, rbus[33:32], rbus[74:72])
                                 : rbus[63:32];
            chk("rnd_allowin", ms_allowin, exp_allow);
            chk("rnd_valid", ms_to_ws_valid, ready);
            chk("rnd_fwd_valid", ms_to_ds_fwd_bus[38], res && rbus[69] && rbus[68:64] != 5'd0);
            if (ready) begin
                chk("rnd_bus", ms_to_ws_bus, {rbus[69], rbus[68:64], exp_res, rbus[31:0]});
                chk("rnd_fwd_data", ms_to_ds_fwd_bus[31:0], exp_res);
            end
            if (res && rbus[70]) chk("rnd_blocked", ms_to_ds_fwd_bus[37], !ready);

            if (ready && ws_allowin) res = 1'b0;
            else if (dok) begin
                got  = 1'b1;
                rdat = cur_rd;
            end
            if (off_v && exp_allow) begin
                res   = 1'b1;
                rbus  = off_bus;
                got   = 1'b0;
                dly   = int'($urandom % 4);
                off_v = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
